mux_2to1: RTL and testbench
===========================

// Module: mux_2to1
// PURPOSE
//   Parameterised 2:1 data selector with a zero-latency combinational output and a
//   registered copy. A saturating counter tracks select toggles for debug/coverage.
//   Generic datapath leaf, instantiated wherever two sources share one sink.
// PARAMETERS
//   WIDTH   1   data width of a, b, c, c_q (>= 1)
//   CNT_W   8   width of sel_toggle_cnt (>= 1)
// PORTS
//   clk             in   1       single clock; all flops rising-edge
//   rst             in   1       asynchronous, active-high reset
//   a               in   WIDTH   data input, selected when sel=0
//   b               in   WIDTH   data input, selected when sel=1
//   sel             in   1       select: 0 -> a, 1 -> b
//   c               out  WIDTH   combinational result, c = sel ? b : a
//   c_q             out  WIDTH   c registered on clk
//   sel_q           out  1       sel registered on clk
//   sel_toggle_cnt  out  CNT_W   saturating count of sel transitions
//   c_par           out  1       even parity of c_q (see CONFIGURATION)
// BEHAVIOUR
//   - c: purely combinational, zero latency, independent of clk/rst. Valid during reset.
//   - X/Z on sel: c follows Verilog ?: semantics. No X-resolution logic.
//   - On rst=1 (async assert): c_q=0, sel_q=0, sel_toggle_cnt=0, c_par=0.
//     All hold while rst=1.
//   - Reset deassertion is taken synchronously at the next clk edge.
//   - Each clk edge with rst=0:
//       c_q <= c (1-cycle latency)
//       sel_q <= sel
//   - Toggle counting: on each clk edge with rst=0 and sel != sel_q,
//     sel_toggle_cnt increments by 1.
//   - Saturation: sel_toggle_cnt holds at 2**CNT_W-1, with no wrap.
//   - The first edge after reset compares against sel_q=0, so sel=1 at that edge
//     counts one toggle.
//   - Toggles shorter than one clk period are not counted. c still reflects them.
//   - Reset mid-operation clears all registered state immediately. c is unaffected.
// CONFIGURATION
//   MUX2TO1_PARITY_EN defined:
//     - c_par is a flop that updates each clk edge to ^c, keeping it aligned with c_q.
//     - c_par resets to 0.
//   MUX2TO1_PARITY_EN undefined:
//     - c_par is tied to 1'b0 and no parity flop is generated.
//   The port list is identical in both configurations.
// STRUCTURE
//   - Package mux_2to1_pkg holds:
//       localparam DEF_WIDTH=1, DEF_CNT_W=8
//       function sat_inc(cnt, max) for the saturating increment
//   - Sub-module mux_2to1_core (WIDTH): combinational c = sel ? b : a.
//   - The top level adds output/select registers, the toggle counter and the
//     optional parity flop.
// TESTING (WIDTH=1, CNT_W=8, 20 ns steps unless noted)
//   1. a=0,b=1,sel=0 -> c=0; then a=0,b=0,sel=1 -> c=0;
//      then a=1,b=1,sel=1 -> c=1; then a=1,b=0,sel=0 -> c=1.
//   2. Exhaustive sweep of all 8 {a,b,sel} combinations -> c == (sel?b:a)
//      in the same delta cycle.
//   3. a=1,b=0, sel switches 0->1 mid-cycle -> c falls immediately;
//      c_q falls at the next clk edge; sel_toggle_cnt becomes 1.
//   4. Toggle sel on every clk edge for 300 edges -> sel_toggle_cnt stops at 255.
//   5. Assert rst asynchronously between edges with c_q=1, cnt=5 ->
//      c_q, sel_q, cnt and c_par go to 0 without waiting for a clk edge;
//      c keeps tracking its inputs.
//   6. WIDTH=8, MUX2TO1_PARITY_EN defined: a=8'h07, sel=0 -> after 1 edge c_q=8'h07, c_par=1.
//      Same stimulus with the macro undefined -> c_par=0.

Source files
------------

// File: rtl/mux_2to1_pkg.sv
// mux_2to1_pkg
//   Shared definitions for the mux_2to1 block:
//     DEF_WIDTH  default data width
//     DEF_CNT_W  default width of the select-toggle counter
//     sat_inc    saturating increment used by the toggle counter
//   sat_inc works on 32-bit values, so counters built on it must be at most
//   32 bits wide.
package mux_2to1_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  // Returns cnt + 1, or cnt unchanged once it has reached max (no wrap).
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] max);
    if (cnt >= max) begin
      return cnt;
    end
    return cnt + 32'd1;
  endfunction

endpackage

// File: rtl/mux_2to1_core.sv
// mux_2to1_core
//   Purely combinational 2:1 selector. No clock and no reset: the output is
//   valid at all times, including while the surrounding logic is in reset.
//   An X/Z on sel resolves through the ordinary ?: operator, with no extra
//   X-handling.
// Ports
//   a    in   WIDTH  selected when sel = 0
//   b    in   WIDTH  selected when sel = 1
//   sel  in   1      select
//   c    out  WIDTH  sel ? b : a
module mux_2to1_core
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] c
);

  assign c = sel ? b : a;

endmodule

// File: rtl/mux_2to1.sv
// mux_2to1
//   2:1 data selector with a zero-latency combinational output, a registered
//   copy of that output, a registered select and a saturating counter of
//   select transitions for debug/coverage.
//
// Configuration macro: MUX2TO1_PARITY_EN
//   defined   : c_par is a flop holding the even parity (^) of the value
//               captured into c_q, so it lines up with c_q.
//   undefined : c_par is tied to 0 and no parity flop exists.
//   The port list is the same in both builds.
//
// Parameters
//   WIDTH  data width of a, b, c, c_q (>= 1)
//   CNT_W  width of sel_toggle_cnt (1..32)
//
// Ports
//   clk             in   1      rising-edge clock
//   rst             in   1      asynchronous, active-high reset
//   a               in   WIDTH  data input, chosen when sel = 0
//   b               in   WIDTH  data input, chosen when sel = 1
//   sel             in   1      select
//   c               out  WIDTH  combinational sel ? b : a
//   c_q             out  WIDTH  c registered on clk
//   sel_q           out  1      sel registered on clk
//   sel_toggle_cnt  out  CNT_W  saturating count of sel transitions
//   c_par           out  1      parity of c_q (0 when parity is disabled)
//
// Reset clears c_q, sel_q, sel_toggle_cnt and c_par immediately and holds
// them at 0; c keeps following its inputs throughout.
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] sel_toggle_cnt,
  output logic             c_par
);

  // Saturation value 2**CNT_W - 1, formed in 32 bits for sat_inc.
  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << CNT_W) - 32'd1);

  logic [WIDTH-1:0] w_c;
  logic [CNT_W-1:0] w_cnt_inc;

  logic [WIDTH-1:0] r_c_q;
  logic             r_sel_q;
  logic [CNT_W-1:0] r_cnt;

  mux_2to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (a),
    .b   (b),
    .sel (sel),
    .c   (w_c)
  );

  assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), CNT_MAX));

  // The toggle counter compares the live select against the value captured
  // on the previous edge, so a pulse on sel that starts and ends between two
  // edges is never seen. Straight after reset r_sel_q is 0, so sel = 1 on
  // the first edge counts as one transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_q   <= '0;
      r_sel_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_c_q   <= w_c;
      r_sel_q <= sel;
      if (sel != r_sel_q) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

`ifdef MUX2TO1_PARITY_EN
  logic r_par;

  // Parity is taken from the same c value that lands in c_q on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else begin
      r_par <= ^w_c;
    end
  end

  assign c_par = r_par;
`else
  assign c_par = 1'b0;
`endif

  assign c              = w_c;
  assign c_q            = r_c_q;
  assign sel_q          = r_sel_q;
  assign sel_toggle_cnt = r_cnt;

endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1
//   Directed bench for mux_2to1. Instance u_dut is the default build
//   (WIDTH=1, CNT_W=8); u_dut8 is a WIDTH=8 build for the parity case.
//   The expected parity value follows MUX2TO1_PARITY_EN so the same bench
//   covers both configurations.
module tb_mux_2to1;

`ifdef MUX2TO1_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       sel;
  logic       c;
  logic       c_q;
  logic       sel_q;
  logic [7:0] cnt;
  logic       c_par;

  logic [7:0] a8;
  logic [7:0] b8;
  logic       sel8;
  logic [7:0] c8;
  logic [7:0] c_q8;
  logic       sel_q8;
  logic [7:0] cnt8;
  logic       c_par8;

  int vec_cnt;
  int err_cnt;

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Watchdog: the sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected sequence end");
    $fatal(1, "bench timed out");
  end

  mux_2to1 #(
    .WIDTH (1),
    .CNT_W (8)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .a              (a),
    .b              (b),
    .sel            (sel),
    .c              (c),
    .c_q            (c_q),
    .sel_q          (sel_q),
    .sel_toggle_cnt (cnt),
    .c_par          (c_par)
  );

  mux_2to1 #(
    .WIDTH (8),
    .CNT_W (8)
  ) u_dut8 (
    .clk            (clk),
    .rst            (rst),
    .a              (a8),
    .b              (b8),
    .sel            (sel8),
    .c              (c8),
    .c_q            (c_q8),
    .sel_q          (sel_q8),
    .sel_toggle_cnt (cnt8),
    .c_par          (c_par8)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst  = 1'b1;
    a    = 1'b0;
    b    = 1'b0;
    sel  = 1'b0;
    a8   = 8'h00;
    b8   = 8'h00;
    sel8 = 1'b0;

    // ---------------------------------------------------- reset state
    #5;
    check("rst_c_q",    32'(c_q),    32'h0);
    check("rst_sel_q",  32'(sel_q),  32'h0);
    check("rst_cnt",    32'(cnt),    32'h0);
    check("rst_c_par",  32'(c_par),  32'h0);
    check("rst_c_q8",   32'(c_q8),   32'h0);
    check("rst_c_par8", 32'(c_par8), 32'h0);
    a = 1'b1;
    #1;
    check("rst_c_live", 32'(c), 32'h1);
    @(posedge clk);
    #1;
    check("rst_hold_c_q", 32'(c_q), 32'h0);

    @(negedge clk);
    rst = 1'b0;

    // ------------------------------------------- directed c vectors
    a = 1'b0; b = 1'b1; sel = 1'b0; #1;
    check("t1_v0", 32'(c), 32'h0);
    a = 1'b0; b = 1'b0; sel = 1'b1; #1;
    check("t1_v1", 32'(c), 32'h0);
    a = 1'b1; b = 1'b1; sel = 1'b1; #1;
    check("t1_v2", 32'(c), 32'h1);
    a = 1'b1; b = 1'b0; sel = 1'b0; #1;
    check("t1_v3", 32'(c), 32'h1);

    // ---------------------------------------- sweep {a,b,sel}
    a = 1'b0; b = 1'b0; sel = 1'b0; #1; check("sw_000", 32'(c), 32'h0);
    a = 1'b0; b = 1'b0; sel = 1'b1; #1; check("sw_001", 32'(c), 32'h0);
    a = 1'b0; b = 1'b1; sel = 1'b0; #1; check("sw_010", 32'(c), 32'h0);
    a = 1'b0; b = 1'b1; sel = 1'b1; #1; check("sw_011", 32'(c), 32'h1);
    a = 1'b1; b = 1'b0; sel = 1'b0; #1; check("sw_100", 32'(c), 32'h1);
    a = 1'b1; b = 1'b0; sel = 1'b1; #1; check("sw_101", 32'(c), 32'h0);
    a = 1'b1; b = 1'b1; sel = 1'b0; #1; check("sw_110", 32'(c), 32'h1);
    a = 1'b1; b = 1'b1; sel = 1'b1; #1; check("sw_111", 32'(c), 32'h1);

    // Clean registered state before the sequential tests.
    @(negedge clk);
    rst = 1'b1;
    a = 1'b1; b = 1'b0; sel = 1'b0;
    #2;
    rst = 1'b0;

    // ------------------------------------- mid-cycle select switch
    @(posedge clk);
    #1;
    check("t3_c_q_pre", 32'(c_q), 32'h1);
    check("t3_cnt_pre", 32'(cnt), 32'h0);
    #4;
    sel = 1'b1;
    #1;
    check("t3_c_fall",    32'(c),   32'h0);
    check("t3_c_q_hold",  32'(c_q), 32'h1);
    @(posedge clk);
    #1;
    check("t3_c_q_fall", 32'(c_q),   32'h0);
    check("t3_sel_q",    32'(sel_q), 32'h1);
    check("t3_cnt",      32'(cnt),   32'h1);

    // Glitch on sel between edges: c follows, the counter does not.
    #3;
    sel = 1'b0;
    #1;
    check("glitch_c", 32'(c), 32'h1);
    #1;
    sel = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_cnt", 32'(cnt), 32'h1);

    // ------------------------------------ build cnt=5, c_q=1; reset
    @(negedge clk); sel = 1'b0;
    @(negedge clk); sel = 1'b1;
    @(negedge clk); sel = 1'b0;
    @(negedge clk); sel = 1'b1; b = 1'b1;
    @(posedge clk);
    #1;
    check("t5_cnt_pre",  32'(cnt),   32'h5);
    check("t5_c_q_pre",  32'(c_q),   32'h1);
    check("t5_c_par_pre", 32'(c_par), 32'(PAR_ON));
    #4;
    rst = 1'b1;
    #1;
    check("t5_c_q",   32'(c_q),   32'h0);
    check("t5_sel_q", 32'(sel_q), 32'h0);
    check("t5_cnt",   32'(cnt),   32'h0);
    check("t5_c_par", 32'(c_par), 32'h0);
    a = 1'b0; sel = 1'b0; #1;
    check("t5_c_track0", 32'(c), 32'h0);
    sel = 1'b1; #1;
    check("t5_c_track1", 32'(c), 32'h1);
    @(posedge clk);
    #1;
    check("t5_cnt_held", 32'(cnt), 32'h0);
    check("t5_c_q_held", 32'(c_q), 32'h0);

    // ------------------------------------------- counter saturation
    @(negedge clk);
    sel = 1'b0;
    rst = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      sel = ~sel;
      @(posedge clk);
      #1;
      if (i == 1)   check("t4_cnt_1",   32'(cnt), 32'd1);
      if (i == 254) check("t4_cnt_254", 32'(cnt), 32'd254);
      if (i == 255) check("t4_cnt_255", 32'(cnt), 32'd255);
    end
    check("t4_cnt_300", 32'(cnt), 32'd255);

    // ---------------------------------------------- wide + parity
    @(negedge clk);
    a8 = 8'h07; b8 = 8'hF0; sel8 = 1'b0;
    @(posedge clk);
    #1;
    check("t6_c_q8",   32'(c_q8),   32'h07);
    check("t6_c_par8", 32'(c_par8), 32'(PAR_ON));
    @(negedge clk);
    sel8 = 1'b1;
    #1;
    check("t6_c8_b", 32'(c8), 32'hF0);
    @(posedge clk);
    #1;
    check("t6_c_q8_b",   32'(c_q8),   32'hF0);
    check("t6_c_par8_b", 32'(c_par8), 32'h0);
    check("t6_cnt8",     32'(cnt8),   32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
